// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified memory port shared by instruction fetch and load/store.
// Round-robin on ties, registered memory outputs, watchdog abort on hung transfers.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_sel
);

    // Counter wide enough to hold TIMEOUT without wrapping before the compare.
    localparam int               CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
    localparam logic             WD_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic              last_d_q,    last_d_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic              bus_err_q,   bus_err_d;

    logic              if_elig;
    logic              d_elig;
    logic              gnt_if;
    logic              gnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              to_hit;

    // Eligibility and round-robin choice; a requester acked this cycle is masked.
    always_comb begin
        if_elig = if_req && !if_ack_q;
        d_elig  = d_req && !d_ack_q;
        gnt_d   = d_elig && (!if_elig || !last_d_q);
        gnt_if  = if_elig && !gnt_d;
    end

    // Watchdog: next count value and whether it reaches the abort threshold.
    always_comb begin
        cnt_inc = cnt_q + CNT_W'(1);
        to_hit  = WD_EN && (cnt_inc == TO_C);
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        bus_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_d) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    cnt_d       = '0;
                    mem_addr_d  = d_addr;
                    mem_we_d    = d_we;
                    mem_wdata_d = d_wdata;
                end else if (gnt_if) begin
                    state_d    = BUSY_IF;
                    last_d_d   = 1'b0;
                    cnt_d      = '0;
                    mem_addr_d = if_addr;
                    mem_we_d   = 1'b0;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                end else if (to_hit) begin
                    state_d   = IDLE;
                    if_ack_d  = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d  = IDLE;
                    d_ack_d  = 1'b1;
                    mem_we_d = 1'b0;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (to_hit) begin
                    state_d   = IDLE;
                    d_ack_d   = 1'b1;
                    bus_err_d = 1'b1;
                    mem_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight transfer.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Port drive: request and mux select follow the registered state.
    always_comb begin
        mem_req   = (state_q != IDLE);
        grant_sel = (state_q == BUSY_D);
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        if_ack    = if_ack_q;
        d_ack     = d_ack_q;
        bus_err   = bus_err_q;
    end

endmodule
